// File: rtl/ras_ctrl_if.sv
// Bundle between the fetch stage, the resolve/retire logic, the return address stack and ras_ctrl.
// master = the controller itself; slave = everything around it (fetch, resolve, RAS).
`timescale 1ns/1ps
interface ras_ctrl_if;
  logic        f_valid;
  logic [31:0] f_instr;
  logic [31:0] f_pc;
  logic        f_ready;
  logic        f_has_entry;
  logic        pred_valid;
  logic [31:0] pred_target;
  logic        retire;
  logic        flush;
  logic        ras_push;
  logic        ras_pop;
  logic [31:0] ras_addr_in;
  logic [31:0] ras_addr_out;
  logic        ras_empty;

  modport master (
    input  f_valid, f_instr, f_pc, retire, flush, ras_addr_out, ras_empty,
    output f_ready, f_has_entry, pred_valid, pred_target, ras_push, ras_pop, ras_addr_in
  );

  modport slave (
    output f_valid, f_instr, f_pc, retire, flush, ras_addr_out, ras_empty,
    input  f_ready, f_has_entry, pred_valid, pred_target, ras_push, ras_pop, ras_addr_in
  );
endinterface

// File: rtl/ras_ctrl.sv
// Fetch-side return address stack controller: classifies JAL/JALR, issues speculative RAS
// push/pop, logs each op in an in-flight FIFO and unwinds it youngest-first after a flush.
`timescale 1ns/1ps
module ras_ctrl #(
    parameter int INFLIGHT = 8
) (
    input logic    clk,
    input logic    rst,
    ras_ctrl_if.master bus
);
    localparam int PW = $clog2(INFLIGHT);
    localparam logic [PW:0] PTR_ONE = (PW+1)'(1);
    localparam logic [PW:0] CAP     = (PW+1)'(INFLIGHT);
    localparam logic [6:0]  OPC_JAL  = 7'b1101111;
    localparam logic [6:0]  OPC_JALR = 7'b1100111;

    typedef enum logic {S_IDLE, S_UNDO} state_e;
    typedef enum logic [1:0] {OP_NONE, OP_PUSH, OP_POP, OP_POPPUSH} op_e;

    state_e      state_q, state_d;
    logic [PW:0] head_q, head_d, tail_q, tail_d;
    logic [PW:0] count, undo_ptr;
    logic        full;

    op_e         op_mem    [INFLIGHT];
    logic [31:0] saved_mem [INFLIGHT];
    logic        wr_en;

    logic [6:0]  opcode;
    logic [4:0]  rd, rs1;
    logic        rd_link, rs1_link;
    op_e         raw_op, fetch_op, undo_op;
    logic [31:0] undo_saved;

    logic        f_ready, f_has_entry, pred_valid, ras_push, ras_pop, accept;
    logic [31:0] pred_target, ras_addr_in;
    logic        unused_instr_bits;

    assign count    = tail_q - head_q;
    assign full     = (count == CAP);
    assign undo_ptr = tail_q - PTR_ONE;

    assign opcode   = bus.f_instr[6:0];
    assign rd       = bus.f_instr[11:7];
    assign rs1      = bus.f_instr[19:15];
    assign rd_link  = (rd == 5'd1) || (rd == 5'd5);
    assign rs1_link = (rs1 == 5'd1) || (rs1 == 5'd5);
    assign unused_instr_bits = ^{bus.f_instr[31:20], bus.f_instr[14:12]};

    assign undo_op    = op_mem[undo_ptr[PW-1:0]];
    assign undo_saved = saved_mem[undo_ptr[PW-1:0]];

    // Link-register hint decode; an empty RAS cannot supply a return target, so pops degrade.
    always_comb begin
        raw_op = OP_NONE;
        if (opcode == OPC_JAL) begin
            if (rd_link) raw_op = OP_PUSH;
        end else if (opcode == OPC_JALR) begin
            if (rd_link && !rs1_link)      raw_op = OP_PUSH;
            else if (!rd_link && rs1_link) raw_op = OP_POP;
            else if (rd_link && rs1_link)  raw_op = (rd == rs1) ? OP_PUSH : OP_POPPUSH;
        end
        fetch_op = raw_op;
        if (bus.ras_empty) begin
            if (raw_op == OP_POP)          fetch_op = OP_NONE;
            else if (raw_op == OP_POPPUSH) fetch_op = OP_PUSH;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_d     = state_q;
        head_d      = head_q;
        tail_d      = tail_q;
        wr_en       = 1'b0;
        accept      = 1'b0;
        f_ready     = 1'b0;
        f_has_entry = 1'b0;
        pred_valid  = 1'b0;
        pred_target = '0;
        ras_push    = 1'b0;
        ras_pop     = 1'b0;
        ras_addr_in = '0;
        case (state_q)
            S_IDLE: begin
                f_ready = !full && !bus.flush;
                accept  = bus.f_valid && f_ready && rst;
                if (accept && fetch_op != OP_NONE) begin
                    f_has_entry = 1'b1;
                    wr_en       = 1'b1;
                    tail_d      = tail_q + PTR_ONE;
                    ras_push    = (fetch_op == OP_PUSH) || (fetch_op == OP_POPPUSH);
                    ras_pop     = (fetch_op == OP_POP)  || (fetch_op == OP_POPPUSH);
                    ras_addr_in = ras_push ? bus.f_pc + 32'd4 : '0;
                    pred_valid  = ras_pop;
                    pred_target = ras_pop ? bus.ras_addr_out : '0;
                end
                if (bus.retire && count != '0) head_d = head_q + PTR_ONE;
                // The retire in the flush cycle is dequeued before deciding whether to unwind.
                if (bus.flush && (tail_q != head_d)) state_d = S_UNDO;
            end
            S_UNDO: begin
                case (undo_op)
                    OP_PUSH: ras_pop = 1'b1;
                    OP_POP: begin
                        ras_push    = 1'b1;
                        ras_addr_in = undo_saved;
                    end
                    OP_POPPUSH: begin
                        ras_push    = 1'b1;
                        ras_pop     = 1'b1;
                        ras_addr_in = undo_saved;
                    end
                    default: ;
                endcase
                tail_d = undo_ptr;
                if (count == PTR_ONE) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    // NOTE: the FIFO storage has no reset; head/tail define which slots are meaningful.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            op_mem[tail_q[PW-1:0]]    <= fetch_op;
            saved_mem[tail_q[PW-1:0]] <= bus.ras_addr_out;
        end
    end

    assign bus.f_ready     = f_ready;
    assign bus.f_has_entry = f_has_entry;
    assign bus.pred_valid  = pred_valid;
    assign bus.pred_target = pred_target;
    assign bus.ras_push    = ras_push;
    assign bus.ras_pop     = ras_pop;
    assign bus.ras_addr_in = ras_addr_in;

    // Retire is only meaningful while idle with something outstanding.
    a_retire_legal: assert property (@(posedge clk) disable iff (!rst)
        bus.retire |-> (state_q == S_IDLE && count != '0));
endmodule
